fc2_accum: RTL and testbench
============================

Name: fc2_accum

Overview:
- Second fully-connected layer core for the binarized FC path.
- Streams 1-bit activations from the FC1 stage into an internal buffer.
- Computes one signed 32-bit pre-activation sum per output neuron from weights/biases held in an external ROM.
- Emits each sum with a single-cycle valid pulse, directly feeding the FC2 ReLU/binarize stage (32-bit data_in, valid_in).

Parameters:
- N_IN, 64, number of input activations (bits) per inference
- N_OUT, 10, number of output neurons
- W_WIDTH, 8, signed weight/bias word width
- ACC_WIDTH, 32, signed accumulator and output width
- ADDR_WIDTH, 10, ROM address width; must satisfy 2^ADDR_WIDTH >= N_OUT*(N_IN+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- act_in  in  1  activation bit (1 = active)
- act_valid  in  1  act_in valid
- act_ready  out  1  block can accept an activation
- rom_addr  out  ADDR_WIDTH  weight ROM read address
- rom_rd  out  1  ROM read enable
- rom_data  in  W_WIDTH  ROM read data, signed, valid exactly 1 cycle after rom_rd
- data_out  out  ACC_WIDTH  signed neuron sum
- valid_out  out  1  single-cycle pulse, data_out valid
- busy  out  1  high in LOAD or COMPUTE
- done  out  1  single-cycle pulse after last neuron emitted

Behaviour:
- Reset: all outputs 0 (act_ready 0 during reset, 1 in first IDLE cycle); FSM to IDLE; counters and accumulator cleared; activation buffer contents don't-care.
- ROM layout: row j occupies addresses j*(N_IN+1) .. j*(N_IN+1)+N_IN. Words 0..N_IN-1 are weights w[j][i]; word N_IN is bias b[j].
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - act_ready=1.
  - First accepted activation (act_valid&act_ready) is stored at index 0, FSM goes to LOAD.
- LOAD:
  - act_ready=1; each accepted bit is stored at the next index.
  - On acceptance of index N_IN-1, act_ready drops the next cycle and FSM goes to COMPUTE.
  - act_valid while act_ready=0 is ignored, with no side effects.
- COMPUTE:
  - rom_rd=1 every cycle. rom_addr increments by 1 from 0 through N_OUT*(N_IN+1)-1, back-to-back with no bubbles across rows.
  - One cycle after each weight address, acc += act[i] ? sign_ext(rom_data) : 0.
  - Bias cycle: data_out <= acc + sign_ext(rom_data) and valid_out=1 for one cycle; acc is cleared for the next row in the same cycle.
  - Arithmetic is two's complement, wrapping modulo 2^ACC_WIDTH.
  - valid_out for neuron j occurs (j+1)*(N_IN+1)+1 cycles after COMPUTE entry, i.e. 66, 131, ... with defaults.
  - data_out holds its value between pulses.
  - After the last address is issued, rom_rd drops; after the final valid_out, FSM goes to DONE.
- DONE: done=1 for one cycle, then IDLE. A new inference may begin on the following cycle.
- Downstream always accepts; there is no backpressure.
- rst_n low in any state aborts within that cycle: no further valid_out or done, partial sums discarded.
- Each inference is independent; buffer bits are only read after being fully rewritten.

Optional Feature:
- Macro FC2_ARGMAX_EN.
- When defined:
  - Adds outputs class_idx (clog2(N_OUT) bits) and class_valid (1 bit).
  - Tracks the running maximum signed data_out and its index during COMPUTE; ties resolve to the lowest index.
  - class_valid pulses coincident with done; class_idx holds until the next class_valid.
  - Both reset to 0.
- When undefined: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Package fc2_pkg:
  - FSM state enum (IDLE, LOAD, COMPUTE, DONE)
  - default N_IN, N_OUT, W_WIDTH, ACC_WIDTH
  - derived localparam ROW_LEN = N_IN+1
- One natural sub-module, fc2_act_buf: N_IN-bit write-by-index, read-by-index register file holding the activations. Everything else stays in fc2_accum.

Test Plan:
- Reset mid-COMPUTE:
  - Stimulus: assert rst_n=0 at cycle 30 of COMPUTE.
  - Required: data_out=0, valid_out=0, done=0, busy=0, act_ready=1 the cycle after release; a fresh inference then yields correct sums.
- All activations 1:
  - Stimulus: ROM weights all +1, biases b[j]=j.
  - Required: data_out = 64+j for j=0..9; valid_out at COMPUTE+66, +131, ..., +651; done one cycle after the last pulse.
- Alternating activations (1,0,1,0...):
  - Stimulus: weights w[j][i] = -128 when i is even, else +127; bias 0.
  - Required: every data_out = -4096; tests sign extension and masking.
- act_valid with gaps:
  - Stimulus: random 1-3 cycle gaps between activations; act_valid held high during COMPUTE.
  - Required: exactly 64 bits captured; act_ready=0 throughout COMPUTE; extra bits are not consumed.
- Back-to-back inferences:
  - Stimulus: second activation vector starts the cycle after done.
  - Required: both sets of 10 sums are correct; no accumulator carry-over.
- With FC2_ARGMAX_EN:
  - Stimulus: biases {5,9,9,-3,0,0,0,0,0,0}, all activations 0.
  - Required: class_idx=1, class_valid coincident with done.

Source files
------------

// File: rtl/fc2_pkg.sv
// Shared state encoding and default geometry for the FC2 accumulator core.
package fc2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } fc2_state_t;

    localparam int FC2_N_IN      = 64;
    localparam int FC2_N_OUT     = 10;
    localparam int FC2_W_WIDTH   = 8;
    localparam int FC2_ACC_WIDTH = 32;
    localparam int ROW_LEN       = FC2_N_IN + 1;

    // Index width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc2_act_buf.sv
// Activation register file: write one bit by index, read one bit by index.
// Write lands on the next edge, read is combinational; no flow control.
module fc2_act_buf
    import fc2_pkg::*;
#(
    parameter int N_IN = FC2_N_IN,
    localparam int IW  = idx_bits(N_IN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_bit,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_bit
);

    // Contents need no reset: every bit is rewritten before it is read.
    logic [N_IN-1:0] bits;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bits[wr_idx] <= wr_bit;
        end
    end

    assign rd_bit = bits[rd_idx];

endmodule

// File: rtl/fc2_accum.sv
// FC2 core: buffers N_IN activation bits, then streams ROM weights to form N_OUT signed sums.
// Sum j appears (j+1)*(N_IN+1)+1 cycles after COMPUTE entry; no downstream backpressure; FC2_ARGMAX_EN adds argmax.
module fc2_accum
    import fc2_pkg::*;
#(
    parameter int N_IN       = FC2_N_IN,
    parameter int N_OUT      = FC2_N_OUT,
    parameter int W_WIDTH    = FC2_W_WIDTH,
    parameter int ACC_WIDTH  = FC2_ACC_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  act_in,
    input  logic                  act_valid,
    output logic                  act_ready,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd,
    input  logic [W_WIDTH-1:0]    rom_data,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
`ifdef FC2_ARGMAX_EN
    ,
    output logic [idx_bits(N_OUT)-1:0] class_idx,
    output logic                       class_valid
`endif
);

    localparam int ROW = N_IN + 1;
    localparam int IW  = idx_bits(N_IN);
    localparam int CW  = idx_bits(ROW);
    localparam int RW  = idx_bits(N_OUT);

    localparam logic [IW-1:0] LAST_IN  = IW'(N_IN - 1);
    localparam logic [CW-1:0] BIAS_COL = CW'(N_IN);
    localparam logic [RW-1:0] LAST_ROW = RW'(N_OUT - 1);

    // Position of the word whose ROM data arrives this cycle.
    typedef struct packed {
        logic          vld;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } rd_tag_t;

    fc2_state_t state, nxt;

    logic [IW-1:0]         wr_idx;
    logic                  accept;
    logic                  issuing;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  last_issue;
    rd_tag_t               tag;
    logic                  act_bit;
    logic                  bias_cyc;
    logic                  fin;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  w_ext;
    logic [ACC_WIDTH-1:0]  sum;

    assign accept     = act_valid && act_ready;
    assign last_issue = issuing && (col == BIAS_COL) && (row == LAST_ROW);
    assign bias_cyc   = tag.vld && (tag.col == BIAS_COL);
    assign w_ext      = {{(ACC_WIDTH-W_WIDTH){rom_data[W_WIDTH-1]}}, rom_data};
    assign sum        = acc + w_ext;
    assign rom_addr   = addr;
    assign rom_rd     = issuing;

    fc2_act_buf #(.N_IN(N_IN)) u_act_buf (
        .clk    (clk),
        .wr_en  (accept),
        .wr_idx (wr_idx),
        .wr_bit (act_in),
        .rd_idx (tag.col[IW-1:0]),
        .rd_bit (act_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    nxt = (wr_idx == LAST_IN) ? COMPUTE : LOAD;
                end
            end
            COMPUTE: begin
                if (valid_out && fin) begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they read 0 while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            wr_idx    <= '0;
            issuing   <= 1'b0;
            addr      <= '0;
            col       <= '0;
            row       <= '0;
            tag       <= '0;
            acc       <= '0;
            fin       <= 1'b0;
        end else begin
            act_ready <= (nxt == IDLE) || (nxt == LOAD);
            busy      <= (nxt == LOAD) || (nxt == COMPUTE);
            done      <= (nxt == DONE);
            valid_out <= 1'b0;

            if (accept) begin
                wr_idx <= (wr_idx == LAST_IN) ? '0 : wr_idx + IW'(1);
            end

            if (state != COMPUTE && nxt == COMPUTE) begin
                issuing <= 1'b1;
                addr    <= '0;
                col     <= '0;
                row     <= '0;
            end else if (issuing) begin
                if (last_issue) begin
                    issuing <= 1'b0;
                    addr    <= '0;
                    col     <= '0;
                    row     <= '0;
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                    if (col == BIAS_COL) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end

            tag.vld <= issuing;
            tag.col <= col;
            tag.row <= row;

            if (bias_cyc) begin
                data_out  <= sum;
                valid_out <= 1'b1;
                acc       <= '0;
                fin       <= (tag.row == LAST_ROW);
            end else if (tag.vld && act_bit) begin
                acc <= sum;
            end

            if (state == DONE) begin
                fin <= 1'b0;
            end
        end
    end

`ifdef FC2_ARGMAX_EN
    logic [ACC_WIDTH-1:0] best_val;
    logic [RW-1:0]        best_idx;

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_val    <= '0;
            best_idx    <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= (nxt == DONE);
            if (bias_cyc && ((tag.row == '0) || ($signed(sum) > $signed(best_val)))) begin
                best_val <= sum;
                best_idx <= tag.row;
            end
            if (nxt == DONE) begin
                class_idx <= best_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc2_accum.sv
// Directed bench for fc2_accum: vector table of activation/ROM patterns with hand-computed sums.
`timescale 1ns/1ps
module tb_fc2_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        act_in;
    logic        act_valid;
    logic        act_ready;
    logic [9:0]  rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic [31:0] data_out;
    logic        valid_out;
    logic        busy;
    logic        done;
`ifdef FC2_ARGMAX_EN
    logic [3:0]  class_idx;
    logic        class_valid;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e_mid;
    int spur;

    logic [7:0] rom [0:1023];

    typedef struct packed {
        logic [63:0]      acts;
        logic [7:0]       w_even;
        logic [7:0]       w_odd;
        logic [9:0][7:0]  bias;
        logic [9:0][31:0] exp;
        logic [3:0]       cls;
        logic             gaps;
        logic             hold;
        logic             b2b;
    } vec_t;

    vec_t tbl [0:6];

    fc2_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
`ifdef FC2_ARGMAX_EN
        ,
        .class_idx   (class_idx),
        .class_valid (class_valid)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // External ROM: data one cycle after the read strobe.
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] a, input int we, input int wo,
                                input int b0, input int bs, input int e0, input int es,
                                input int cls, input bit g, input bit h, input bit bb);
        vec_t v;
        v.acts   = a;
        v.w_even = 8'(we);
        v.w_odd  = 8'(wo);
        for (int j = 0; j < 10; j++) begin
            v.bias[j] = 8'(b0 + bs * j);
            v.exp[j]  = 32'(e0 + es * j);
        end
        v.cls  = 4'(cls);
        v.gaps = g;
        v.hold = h;
        v.b2b  = bb;
        return v;
    endfunction

    task automatic load_rom(input vec_t v);
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 64; i++) rom[j*65+i] = (i % 2 == 0) ? v.w_even : v.w_odd;
            rom[j*65+64] = v.bias[j];
        end
    endtask

    // Starts at posedge+1; returns e = cycle count at COMPUTE entry.
    task automatic drive_bits(input logic [63:0] a, input bit gaps, output int e);
        bit ok;
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                act_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            act_valid = 1'b1;
            act_in    = a[i];
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                ok = act_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL act_accept: bit %0d not accepted within 20 cycles", i);
                finish_run();
            end
        end
        e = cyc;
    endtask

    task automatic run(input vec_t v, input string tag);
        int e, k, dcyc, rel, ar_bad, bz_bad, rom_bad, hold_bad;
        bit got_done;
        load_rom(v);
        @(posedge clk);
        #1;
        drive_bits(v.acts, v.gaps, e);
        act_valid = v.hold;
        act_in    = 1'($urandom_range(0, 1));
        k = 0; dcyc = 0; got_done = 1'b0;
        ar_bad = 0; bz_bad = 0; rom_bad = 0; hold_bad = 0;
        for (int t = 0; t < 800 && !got_done; t++) begin
            @(negedge clk);
            rel = cyc - e;
            if (act_ready !== 1'b0) ar_bad++;
            if (busy !== !done) bz_bad++;
            if (rom_rd !== (rel < 650)) rom_bad++;
            else if (rom_rd && rom_addr !== 10'(rel)) rom_bad++;
            if (valid_out === 1'b1) begin
                if (k < 10) begin
                    chk({tag, " valid_cycle"}, rel, (k + 1) * 65 + 1);
                    chk({tag, " sum"}, $signed(data_out), $signed(v.exp[k]));
                end
                k++;
            end else if (k > 0 && k <= 10 && data_out !== v.exp[k-1]) begin
                hold_bad++;
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                dcyc = rel;
`ifdef FC2_ARGMAX_EN
                chk({tag, " class_valid"}, class_valid, 1);
                chk({tag, " class_idx"}, class_idx, v.cls);
`endif
            end
        end
        chk({tag, " done_seen"}, got_done, 1);
        chk({tag, " done_cycle"}, dcyc, 652);
        chk({tag, " pulse_count"}, k, 10);
        chk({tag, " act_ready_low_cycles_bad"}, ar_bad, 0);
        chk({tag, " busy_bad"}, bz_bad, 0);
        chk({tag, " rom_seq_bad"}, rom_bad, 0);
        chk({tag, " data_hold_bad"}, hold_bad, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        act_valid = 1'b0;
        act_in    = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;

        tbl[0] = mk('1,                     1,    1,    0,    1,    64,    1, 9, 0, 0, 0);
        tbl[1] = mk(64'h5555_5555_5555_5555, -128, 127,  0,    0,    -4096, 0, 0, 1, 0, 0);
        tbl[2] = mk(64'hAAAA_AAAA_AAAA_AAAA, -128, 127,  0,    0,    4064,  0, 0, 1, 1, 0);
        tbl[3] = mk(64'h0,                   -1,   -1,   -20,  3,    -20,   3, 9, 0, 0, 1);
        tbl[4] = mk('1,                      -128, -128, -128, 0,    -8320, 0, 0, 0, 0, 0);
        tbl[5] = mk(64'h0000_0000_FFFF_FFFF, 5,    -3,   7,    -2,   39,   -2, 0, 0, 1, 1);
        tbl[6] = mk(64'h0,                   100,  100,  0,    0,    0,     0, 1, 0, 0, 0);
        tbl[6].bias[0] = 8'd5;  tbl[6].exp[0] = 32'd5;
        tbl[6].bias[1] = 8'd9;  tbl[6].exp[1] = 32'd9;
        tbl[6].bias[2] = 8'd9;  tbl[6].exp[2] = 32'd9;
        tbl[6].bias[3] = 8'hFD; tbl[6].exp[3] = 32'hFFFF_FFFD;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst act_ready", act_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst valid_out", valid_out, 0);
        chk("rst done", done, 0);
        chk("rst data_out", $signed(data_out), 0);
        chk("rst rom_rd", rom_rd, 0);
        chk("rst rom_addr", rom_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle act_ready", act_ready, 1);
        chk("idle busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            if (!tbl[v].b2b) begin
                act_valid = 1'b0;
                repeat (4) @(negedge clk);
            end
            run(tbl[v], $sformatf("v%0d", v));
        end

        // Abort an inference 30 cycles into COMPUTE.
        act_valid = 1'b0;
        repeat (4) @(negedge clk);
        load_rom(tbl[0]);
        @(posedge clk);
        #1;
        drive_bits(tbl[0].acts, 1'b0, e_mid);
        act_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort data_out", $signed(data_out), 0);
        chk("abort valid_out", valid_out, 0);
        chk("abort done", done, 0);
        chk("abort busy", busy, 0);
        chk("abort act_ready", act_ready, 1);
        chk("abort rom_rd", rom_rd, 0);
        spur = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (valid_out !== 1'b0 || done !== 1'b0 || rom_rd !== 1'b0) spur++;
        end
        chk("abort no_late_activity", spur, 0);
        run(tbl[3], "after_abort");

        act_valid = 1'b0;
        repeat (4) @(negedge clk);
        run(tbl[6], "argmax_bias");

        finish_run();
    end

endmodule
